// File: rtl/video_mode_detector.sv
// Video timing mode detector: measures hsync line period and lines per frame,
// and locks onto a mode once enough consecutive frames agree.
module video_mode_detector #(
  parameter int STABLE_FRAMES = 4,
  parameter int HTOL          = 8,
  parameter int VSYNC_TIMEOUT = 5000000
) (
  input  logic        clk_50mhz_in,
  input  logic        reset_n_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        signal_present_in,
  output logic [15:0] line_period_out,
  output logic [10:0] lines_per_frame_out,
  output logic [1:0]  hfreq_class_out,
  output logic        interlaced_out,
  output logic        mode_valid_out,
  output logic        mode_changed_out
);

  localparam int VT_W = $clog2(VSYNC_TIMEOUT + 1);
  localparam int SF_W = $clog2(STABLE_FRAMES + 1);
  localparam logic [VT_W-1:0] VT_LIM = VT_W'(VSYNC_TIMEOUT);
  localparam logic [SF_W-1:0] SF_LIM = SF_W'(STABLE_FRAMES);

  localparam logic [1:0] S_NO_SIGNAL = 2'd0;
  localparam logic [1:0] S_MEASURE   = 2'd1;
  localparam logic [1:0] S_LOCKED    = 2'd2;

  function automatic logic [15:0] absdiff16(input logic [15:0] a, input logic [15:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  function automatic logic [10:0] absdiff11(input logic [10:0] a, input logic [10:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  function automatic logic [1:0] classify(input logic [15:0] p);
    if (p < 16'd1400 || p > 16'd3600) return 2'd3;
    else if (p < 16'd1850)            return 2'd2;
    else if (p < 16'd2600)            return 2'd1;
    else                              return 2'd0;
  endfunction

  logic [2:0]      hs_sync_q, hs_sync_d, vs_sync_q, vs_sync_d;
  logic [15:0]     hcnt_q, hcnt_d, period_q, period_d, prev_period_q, prev_period_d;
  logic [10:0]     lcnt_q, lcnt_d, prev_lines_q, prev_lines_d;
  logic [VT_W-1:0] vcnt_q, vcnt_d;
  logic [SF_W-1:0] stab_q, stab_d;
  logic [1:0]      state_q, state_d;
  logic [15:0]     line_period_q, line_period_d;
  logic [10:0]     lines_q, lines_d;
  logic [1:0]      class_q, class_d;
  logic            interlaced_q, interlaced_d;
  logic            valid_q, valid_d;
  logic            changed_q, changed_d;

  logic        hs_edge, vs_edge, timeout, frame_ok;
  logic [15:0] cur_period;
  logic [10:0] cur_lines;
  logic [1:0]  cur_class;

  // [0] first sync flop, [1] synchronized level, [2] its previous value
  assign hs_edge    = hs_sync_q[2] & ~hs_sync_q[1];
  assign vs_edge    = vs_sync_q[2] & ~vs_sync_q[1];
  assign cur_period = hs_edge ? hcnt_q : period_q;
  assign cur_lines  = (hs_edge && lcnt_q != 11'h7FF) ? lcnt_q + 11'd1 : lcnt_q;
  assign cur_class  = classify(cur_period);
  assign timeout    = (vcnt_q >= VT_LIM);
  assign frame_ok   = (absdiff16(cur_period, prev_period_q) <= 16'(HTOL)) &&
                      (absdiff11(cur_lines, prev_lines_q) <= 11'd1);

  always_comb begin
    hs_sync_d     = {hs_sync_q[1:0], hsync_in};
    vs_sync_d     = {vs_sync_q[1:0], vsync_in};
    hcnt_d        = hcnt_q;
    period_d      = period_q;
    prev_period_d = prev_period_q;
    prev_lines_d  = prev_lines_q;
    lcnt_d        = cur_lines;
    vcnt_d        = vcnt_q;
    stab_d        = stab_q;
    state_d       = state_q;
    line_period_d = line_period_q;
    lines_d       = lines_q;
    class_d       = class_q;
    interlaced_d  = interlaced_q;
    changed_d     = 1'b0;

    if (hs_edge) begin
      period_d = hcnt_q;
      hcnt_d   = 16'd1;
    end else if (hcnt_q != 16'hFFFF) begin
      hcnt_d = hcnt_q + 16'd1;
    end

    if (vs_edge) begin
      lcnt_d        = '0;
      vcnt_d        = '0;
      prev_period_d = cur_period;
      prev_lines_d  = cur_lines;
    end else if (vcnt_q < VT_LIM) begin
      vcnt_d = vcnt_q + VT_W'(1);
    end

    case (state_q)
      S_NO_SIGNAL: begin
        stab_d = '0;
        if (signal_present_in) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        if (timeout) begin
          stab_d = '0;
          vcnt_d = '0;
          lcnt_d = '0;
        end else if (vs_edge) begin
          if (frame_ok && cur_class != 2'd3) begin
            if (stab_q + SF_W'(1) == SF_LIM) begin
              state_d = S_LOCKED;
              stab_d  = '0;
            end else begin
              stab_d = stab_q + SF_W'(1);
            end
          end else begin
            stab_d = '0;
          end
        end
      end
      S_LOCKED: begin
        if (timeout) begin
          state_d = S_MEASURE;
          stab_d  = '0;
          vcnt_d  = '0;
          lcnt_d  = '0;
        end else if (vs_edge && !frame_ok) begin
          state_d = S_MEASURE;
          stab_d  = '0;
        end
      end
      default: state_d = S_NO_SIGNAL;
    endcase

    // Loss of signal overrides every other transition, including a lock entry
    if (!signal_present_in) begin
      state_d = S_NO_SIGNAL;
      hcnt_d  = '0;
      lcnt_d  = '0;
      stab_d  = '0;
      vcnt_d  = '0;
    end

    if (state_d == S_LOCKED && state_q != S_LOCKED) begin
      line_period_d = cur_period;
      lines_d       = (cur_lines > prev_lines_q) ? cur_lines : prev_lines_q;
      class_d       = cur_class;
      interlaced_d  = (absdiff11(cur_lines, prev_lines_q) == 11'd1);
      changed_d     = 1'b1;
    end

    valid_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk_50mhz_in) begin
    if (!reset_n_in) begin
      hs_sync_q     <= 3'b111;
      vs_sync_q     <= 3'b111;
      hcnt_q        <= '0;
      period_q      <= '0;
      prev_period_q <= '0;
      prev_lines_q  <= '0;
      lcnt_q        <= '0;
      vcnt_q        <= '0;
      stab_q        <= '0;
      state_q       <= S_NO_SIGNAL;
      line_period_q <= '0;
      lines_q       <= '0;
      class_q       <= 2'd3;
      interlaced_q  <= 1'b0;
      valid_q       <= 1'b0;
      changed_q     <= 1'b0;
    end else begin
      hs_sync_q     <= hs_sync_d;
      vs_sync_q     <= vs_sync_d;
      hcnt_q        <= hcnt_d;
      period_q      <= period_d;
      prev_period_q <= prev_period_d;
      prev_lines_q  <= prev_lines_d;
      lcnt_q        <= lcnt_d;
      vcnt_q        <= vcnt_d;
      stab_q        <= stab_d;
      state_q       <= state_d;
      line_period_q <= line_period_d;
      lines_q       <= lines_d;
      class_q       <= class_d;
      interlaced_q  <= interlaced_d;
      valid_q       <= valid_d;
      changed_q     <= changed_d;
    end
  end

  assign line_period_out     = line_period_q;
  assign lines_per_frame_out = lines_q;
  assign hfreq_class_out     = class_q;
  assign interlaced_out      = interlaced_q;
  assign mode_valid_out      = valid_q;
  assign mode_changed_out    = changed_q;

endmodule
